// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide, sign fix-up.
// Optional MD_EARLY_OUT_EN: divide-by-zero and signed-overflow requests bypass the iteration phase.
module mul_div_unit #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] MD_In_A,
  input  logic [DWIDTH-1:0] MD_In_B,
  input  logic [2:0]        MD_OP,
  input  logic              MD_Start,
  input  logic              MD_Flush,
  output logic              MD_Ready,
  output logic              MD_Done,
  output logic [DWIDTH-1:0] MD_Out
);

  localparam int CW = $clog2(DWIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state, state_next;
  logic [2*DWIDTH-1:0] acc;
  logic [DWIDTH-1:0]   opnd;
  logic [DWIDTH-1:0]   special_val;
  logic [DWIDTH-1:0]   out_q;
  logic [2:0]          op;
  logic                neg_q, neg_r, special;
  logic [CW-1:0]       cnt;

  // Request decode, evaluated on the raw inputs at the accepting edge
  logic              accept, is_div, signed_div, a_sgn, b_sgn;
  logic              div_zero, div_ovf, req_special;
  logic [DWIDTH-1:0] a_mag, b_mag, req_special_val;

  assign accept     = MD_Start && (state == IDLE) && !MD_Flush;
  assign is_div     = MD_OP[2];
  assign signed_div = MD_OP[2] && !MD_OP[0];
  assign a_sgn      = MD_In_A[DWIDTH-1] && (signed_div || MD_OP == 3'd1 || MD_OP == 3'd2);
  assign b_sgn      = MD_In_B[DWIDTH-1] && (signed_div || MD_OP == 3'd1);
  assign a_mag      = a_sgn ? -MD_In_A : MD_In_A;
  assign b_mag      = b_sgn ? -MD_In_B : MD_In_B;
  assign div_zero   = is_div && (MD_In_B == '0);
  assign div_ovf    = signed_div && (MD_In_A == {1'b1, {(DWIDTH-1){1'b0}}}) && (MD_In_B == '1);
  assign req_special = div_zero || div_ovf;

  always_comb begin
    req_special_val = '0;
    if (div_zero)
      req_special_val = MD_OP[1] ? MD_In_A : '1;
    else if (div_ovf)
      req_special_val = MD_OP[1] ? '0 : MD_In_A;
  end

  // One iteration step of each algorithm; acc holds {high/remainder, low/quotient}
  logic [DWIDTH:0]     mul_sum;
  logic [2*DWIDTH-1:0] mul_next;
  logic [DWIDTH:0]     div_shift;
  logic [DWIDTH+1:0]   div_diff;
  logic [2*DWIDTH-1:0] div_next;

  assign mul_sum   = {1'b0, acc[2*DWIDTH-1:DWIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next  = {mul_sum, acc[DWIDTH-1:1]};
  assign div_shift = {acc[2*DWIDTH-1:DWIDTH], acc[DWIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd};
  assign div_next  = div_diff[DWIDTH+1] ? {div_shift[DWIDTH-1:0], acc[DWIDTH-2:0], 1'b0}
                                        : {div_diff[DWIDTH-1:0], acc[DWIDTH-2:0], 1'b1};

  // Sign fix-up and result selection
  logic [2*DWIDTH-1:0] prod_fix;
  logic [DWIDTH-1:0]   quot_fix, rem_fix, fix_result;

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quot_fix = neg_q ? -acc[DWIDTH-1:0] : acc[DWIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*DWIDTH-1:DWIDTH] : acc[2*DWIDTH-1:DWIDTH];
    if (special)
      fix_result = special_val;
    else if (!op[2])
      fix_result = (op == 3'd0) ? prod_fix[DWIDTH-1:0] : prod_fix[2*DWIDTH-1:DWIDTH];
    else
      fix_result = op[1] ? rem_fix : quot_fix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef MD_EARLY_OUT_EN
          state_next = req_special ? FIX : CALC;
`else
          state_next = CALC;
`endif
        end
      end
      CALC:    if (cnt == CW'(DWIDTH-1)) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (MD_Flush)
      state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      opnd        <= '0;
      special_val <= '0;
      out_q       <= '0;
      op          <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      special     <= 1'b0;
      cnt         <= '0;
    end else begin
      if (accept) begin
        op          <= MD_OP;
        special     <= req_special;
        special_val <= req_special_val;
        neg_q       <= a_sgn ^ b_sgn;
        neg_r       <= a_sgn;
        cnt         <= '0;
        acc         <= {{DWIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
        opnd        <= is_div ? b_mag : a_mag;
      end else if (state == CALC && !MD_Flush) begin
        cnt <= cnt + 1'b1;
        acc <= op[2] ? div_next : mul_next;
      end
      // A flush during FIX must leave the previous result visible
      if (state == FIX && !MD_Flush)
        out_q <= fix_result;
    end
  end

  assign MD_Ready = (state == IDLE);
  assign MD_Done  = (state == DONE);
  assign MD_Out   = out_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed RV32M corner cases, random ops vs. a 64-bit
// arithmetic reference, latency/pulse checks, flush and mid-operation reset.
module tb_mul_div_unit;
  localparam int W = 32;

  logic         clk, rst_n, start, flush;
  logic [W-1:0] in_a, in_b;
  logic [2:0]   op;
  logic         ready, done;
  logic [W-1:0] out;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] last_exp = '0;

  mul_div_unit #(.DWIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .MD_In_A(in_a), .MD_In_B(in_b), .MD_OP(op),
    .MD_Start(start), .MD_Flush(flush), .MD_Ready(ready), .MD_Done(done), .MD_Out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic following the RV32M definitions
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint          ub = longint'({32'b0, b});
    longint unsigned ua = 64'(a);
    longint unsigned uu = 64'(b);
    logic [63:0]     p;
    logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = ua * uu; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * uu; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MD_EARLY_OUT_EN
    if (o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 2;
`endif
    return W + 2;
  endfunction

  // Accept, scramble inputs, measure latency (accept cycle counted as 1), check result and pulse
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp);
    int n = 0;
    int k = 0;
    logic seen = 1'b0;
    while (!ready && k < 100) begin tick(); k++; end
    op = o; in_a = a; in_b = b; start = 1'b1;
    tick();
    start = 1'b0; op = 3'($urandom); in_a = $urandom; in_b = $urandom;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      n++;
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(n + 1), 32'(exp_latency(o, a, b)));
    check({tag, "_result"}, out, exp);
    $display("op=%0d a=%h b=%h -> out=%h exp=%h latency=%0d", o, a, b, out, exp, n + 1);
    last_exp = exp;
    tick();
    check({tag, "_pulse_once"}, 32'(done), 32'd0);
    check({tag, "_held"}, out, exp);
    check({tag, "_ready_after"}, 32'(ready), 32'd1);
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    int hits = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) hits++;
    end
    check(tag, 32'(hits), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; in_a = '0; in_b = '0;
    tick(); tick();
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_out", out, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("mul_7x6", 3'd0, 32'd7, 32'd6, 32'd42);
    run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulhsu_m1x2", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op("remu_by0", 3'd7, 32'd5, 32'd0, 32'd5);
    run_op("div_by0", 3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    run_op("rem_by0", 3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_op("divu_nonovf", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]   ro = 3'($urandom_range(0, 7));
      logic [W-1:0] ra = $urandom;
      logic [W-1:0] rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 4) == 0) ra = -ra;
      run_op("random", ro, ra, rb, model(ro, ra, rb));
    end

    // Flush ten cycles into a divide: back to idle, no pulse, previous result kept
    op = 3'd4; in_a = 32'd1000; in_b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_ready", 32'(ready), 32'd1);
    check("flush_done", 32'(done), 32'd0);
    check("flush_out_kept", out, last_exp);
    $display("flush mid-DIV: ready=%0d out=%h", ready, out);
    watch_no_done("flush_no_done", W + 8);
    run_op("mul_3x3_after_flush", 3'd0, 32'd3, 32'd3, 32'd9);

    // Flush and start together in idle: request dropped
    op = 3'd0; in_a = 32'd5; in_b = 32'd5; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_start_ready", 32'(ready), 32'd1);
    $display("flush+start in idle: ready=%0d", ready);
    watch_no_done("flush_start_no_done", W + 8);

    // Start held high through a busy op, then async reset mid-CALC
    op = 3'd5; in_a = 32'd99; in_b = 32'd4; start = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    check("busy_not_ready", 32'(ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_ready", 32'(ready), 32'd1);
    check("async_reset_done", 32'(done), 32'd0);
    check("async_reset_out", out, 32'd0);
    $display("async reset mid-CALC: ready=%0d done=%0d out=%h", ready, done, out);
    start = 1'b0;
    tick();
    rst_n = 1'b1;
    watch_no_done("reset_no_done", W + 8);
    run_op("divu_after_reset", 3'd5, 32'd99, 32'd4, 32'd24);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
